// File: rtl/rst_seq_pkg.sv
// Shared types and default timing for the staged reset sequencer.
// Pure declarations; no logic, no latency, no backpressure.
package rst_seq_pkg;

   localparam int DEF_NUM_STAGES  = 3;
   localparam int DEF_HOLD_CYCLES = 8;
   localparam int DEF_STAGE_DELAY = 16;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      SEQ  = 2'd1,
      RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/rst_sync2.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the 2nd clk edge after rst falls.
// Latency 2 clk on release, 0 on assertion; no backpressure.
module rst_sync2 (
   input  logic clk,
   input  logic rst,
   output logic rst_s
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta  <= 1'b1;
         rst_s <= 1'b1;
      end else begin
         meta  <= 1'b0;
         rst_s <= meta;
      end
   end

endmodule

// File: rtl/rst_sequencer.sv
// Ordered multi-domain reset release: hold all stages, then free them one by one, bit 0 first.
// First release HOLD_CYCLES after sync release or soft request, then every STAGE_DELAY; no backpressure.
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES  = DEF_NUM_STAGES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int STAGE_DELAY = DEF_STAGE_DELAY
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sw_rst_req,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  ready,
   output logic                  busy
);

   localparam int CNT_MAX = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(NUM_STAGES + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SEQ_LAST  = CNT_W'(STAGE_DELAY - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

   logic                  rst_s;
   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;

   rst_sync2 u_rst_sync2 (
      .clk   (clk),
      .rst   (rst),
      .rst_s (rst_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= HOLD;
         cnt_q     <= '0;
         idx_q     <= '0;
         rst_out_q <= '1;
         ready_q   <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   // Releasing by shifting in zeros from bit 0 makes out-of-order release impossible.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rst_out_d = rst_out_q;
      ready_d   = ready_q;
      busy_d    = busy_q;

      if (rst_s || sw_rst_req) begin
         state_d   = HOLD;
         cnt_d     = '0;
         idx_d     = '0;
         rst_out_d = '1;
         ready_d   = 1'b0;
         busy_d    = 1'b1;
      end else begin
         case (state_q)
            HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  rst_out_d = rst_out_q << 1;
                  cnt_d     = '0;
                  idx_d     = IDX_W'(1);
                  if (NUM_STAGES == 1) begin
                     state_d = RUN;
                     ready_d = 1'b1;
                     busy_d  = 1'b0;
                  end else begin
                     state_d = SEQ;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            SEQ: begin
               if (cnt_q == SEQ_LAST) begin
                  rst_out_d = rst_out_q << 1;
                  cnt_d     = '0;
                  idx_d     = idx_q + IDX_W'(1);
                  if (idx_q == IDX_LAST) begin
                     state_d = RUN;
                     ready_d = 1'b1;
                     busy_d  = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
            end
            default: begin
               state_d   = HOLD;
               cnt_d     = '0;
               idx_d     = '0;
               rst_out_d = '1;
               ready_d   = 1'b0;
               busy_d    = 1'b1;
            end
         endcase
      end
   end

   assign rst_out = rst_out_q;
   assign ready   = ready_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed timeline scenarios plus random soft/async resets,
// checked against a model that derives released stage count from cycles since the last restart.
module tb_rst_sequencer;

   localparam int N = 3;
   localparam int H = 8;
   localparam int D = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sw_rst_req = 1'b0;
   logic [N-1:0] rst_out;
   logic         ready;
   logic         busy;

   int tests = 0;
   int fails = 0;
   int sync_edges = 0;   // edges seen since rst fell (model of the synchronizer)
   int t = 0;            // counting edges since the last restart

   always #5 clk = ~clk;

   rst_sequencer #(
      .NUM_STAGES  (N),
      .HOLD_CYCLES (H),
      .STAGE_DELAY (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sw_rst_req (sw_rst_req),
      .rst_out    (rst_out),
      .ready      (ready),
      .busy       (busy)
   );

   function automatic int released(input int tt);
      int r;
      if (tt < H) return 0;
      r = 1 + (tt - H) / D;
      if (r > N) r = N;
      return r;
   endfunction

   function automatic logic [N-1:0] exp_rst_out(input int r);
      logic [N-1:0] v;
      v = '1;
      for (int i = 0; i < N; i++)
         if (i < r) v[i] = 1'b0;
      return v;
   endfunction

   function automatic logic ordered(input logic [N-1:0] v);
      for (int i = 0; i < N - 1; i++)
         if (v[i] && !v[i+1]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int r;
      r = released(t);
      check("rst_out", 32'(rst_out), 32'(exp_rst_out(r)));
      check("ready", 32'(ready), 32'(r == N));
      check("busy", 32'(busy), 32'(r != N));
      check("order", 32'(ordered(rst_out)), 32'd1);
   endtask

   // One clock: drive on negedge, update model at posedge, sample 1 ns later.
   task automatic tick(input logic sw);
      @(negedge clk);
      sw_rst_req = sw;
      @(posedge clk);
      if (sync_edges < 2 || sw) t = 0;
      else if (t < 1000000) t++;
      if (sync_edges < 2) sync_edges++;
      #1;
      check_outputs();
   endtask

   // Called just after a sampled posedge; the pulse ends before the next edge.
   task automatic pulse_rst();
      #1 rst = 1'b1;
      sync_edges = 0;
      t = 0;
      #1 check_outputs();
      check("async_rst_out", 32'(rst_out), 32'h7);
      #1 rst = 1'b0;
   endtask

   // Full release timeline from rst falling; edge 1 is the first posedge after release.
   task automatic run_power_on(input string pfx);
      for (int e = 1; e <= 45; e++) begin
         tick(1'b0);
         if (e == 9)  check({pfx, "_e9"},  32'(rst_out), 32'h7);
         if (e == 10) check({pfx, "_e10"}, 32'(rst_out), 32'h6);
         if (e == 25) check({pfx, "_e25"}, 32'(rst_out), 32'h6);
         if (e == 26) check({pfx, "_e26"}, 32'(rst_out), 32'h4);
         if (e == 41) check({pfx, "_e41_ready"}, 32'(ready), 32'd0);
         if (e == 42) begin
            check({pfx, "_e42"}, 32'(rst_out), 32'h0);
            check({pfx, "_e42_ready"}, 32'(ready), 32'd1);
            check({pfx, "_e42_busy"}, 32'(busy), 32'd0);
         end
      end
   endtask

   initial begin
      int roll;

      #12;
      check_outputs();
      check("reset_rst_out", 32'(rst_out), 32'h7);
      check("reset_busy", 32'(busy), 32'd1);

      @(posedge clk);
      #2 rst = 1'b0;
      sync_edges = 0;
      t = 0;
      run_power_on("po");

      // Soft request in RUN
      tick(1'b1);
      check("soft_run_E", 32'(rst_out), 32'h7);
      check("soft_run_E_ready", 32'(ready), 32'd0);
      for (int k = 1; k <= 40; k++) begin
         tick(1'b0);
         if (k == 7)  check("soft_run_E7", 32'(rst_out), 32'h7);
         if (k == 8)  check("soft_run_E8", 32'(rst_out), 32'h6);
         if (k == 39) check("soft_run_E39_ready", 32'(ready), 32'd0);
         if (k == 40) check("soft_run_E40_ready", 32'(ready), 32'd1);
      end

      // Soft request mid-SEQ, while rst_out is 3'b110
      tick(1'b1);
      for (int k = 1; k <= 12; k++) tick(1'b0);
      check("midseq_pre", 32'(rst_out), 32'h6);
      tick(1'b1);
      check("midseq_E", 32'(rst_out), 32'h7);
      for (int k = 1; k <= 8; k++) begin
         tick(1'b0);
         if (k == 8) check("midseq_E8", 32'(rst_out), 32'h6);
      end
      for (int k = 1; k <= 40; k++) tick(1'b0);

      // Held soft request for 10 edges
      for (int k = 1; k <= 10; k++) begin
         tick(1'b1);
         check("held_hi", 32'(rst_out), 32'h7);
      end
      for (int k = 1; k <= 8; k++) begin
         tick(1'b0);
         if (k == 7) check("held_k7", 32'(rst_out), 32'h7);
         if (k == 8) check("held_k8", 32'(rst_out), 32'h6);
      end
      for (int k = 1; k <= 40; k++) tick(1'b0);

      // Short async reset pulse in RUN, then full sequence again
      pulse_rst();
      check("async_ready", 32'(ready), 32'd0);
      run_power_on("ar");

      // Random soft requests, held requests and async pulses
      for (int n = 0; n < 800; n++) begin
         roll = int'($urandom_range(0, 199));
         if (roll < 4) begin
            tick(1'b1);
         end else if (roll < 6) begin
            repeat ($urandom_range(2, 12)) tick(1'b1);
         end else if (roll == 6) begin
            pulse_rst();
         end else begin
            tick(1'b0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_STAGES, 3, number of ordered reset domains (1..8)
- HOLD_CYCLES, 8, minimum cycles all stages stay asserted after synchronized reset release or a soft request (>=1)
- STAGE_DELAY, 16, cycles between consecutive stage releases (>=1)

REQ-002 Ports SHALL be, one per line:
- clk, input, 1, system clock
- rst, input, 1, reset, asynchronous, active-high
- sw_rst_req, input, 1, soft reset request, synchronous to clk, level-sampled
- rst_out, output, NUM_STAGES, per-stage reset, active-high; bit 0 released first
- ready, output, 1, high when all stages are released
- busy, output, 1, high while the sequence is in HOLD or SEQ

Function
REQ-003 The block SHALL internally produce rst_s through a two-flop synchronizer: asserted asynchronously with rst, deasserted on the 2nd rising clk edge after rst falls.
REQ-004 The FSM SHALL have exactly three states:
- HOLD: all stages asserted
- SEQ: stages being released in order
- RUN: all stages released
REQ-005 While rst_s is high, the FSM SHALL be in HOLD with cnt=0, stage index idx=0, rst_out all ones, ready=0, busy=1.
REQ-006 In HOLD with rst_s low, cnt SHALL increment each edge; on the edge where cnt==HOLD_CYCLES-1:
- rst_out[0] clears
- cnt returns to 0
- idx becomes 1
- the FSM enters SEQ, or RUN if NUM_STAGES==1
REQ-007 In SEQ, cnt SHALL increment each edge; on the edge where cnt==STAGE_DELAY-1:
- rst_out[idx] clears
- cnt returns to 0
- idx increments
REQ-008 On the edge that clears rst_out[NUM_STAGES-1], the FSM SHALL enter RUN, set ready=1 and set busy=0.
REQ-009 Stages SHALL release strictly in index order. A lower-index bit SHALL never be asserted while a higher-index bit is deasserted.
REQ-010 When sw_rst_req=1 at any rising edge, in any state, on that edge:
- rst_out becomes all ones
- ready becomes 0
- busy becomes 1
- state becomes HOLD, with cnt=0 and idx=0
This SHALL take priority over REQ-006 and REQ-007 on the same edge.
REQ-011 If sw_rst_req is held high, the sequence SHALL stay in HOLD with cnt=0. Counting SHALL begin on the first edge at which sw_rst_req=0 is sampled.
REQ-012 Counter widths SHALL be sized as follows, with no wrap-around reachable:
- cnt: $clog2(max(HOLD_CYCLES, STAGE_DELAY)+1) bits
- idx: $clog2(NUM_STAGES+1) bits
REQ-013 All outputs SHALL come directly from flops, with no combinational path from any input to any output.

Reset
REQ-014 rst high SHALL asynchronously force:
- synchronizer flops to the asserted value
- FSM to HOLD
- cnt and idx to 0
- rst_out all ones
- ready=0, busy=1
REQ-015 rst asserted mid-sequence or in RUN SHALL re-assert all stages immediately, with no clock required.
REQ-016 Reset release SHALL restart the full sequence, timed from the synchronized release as in REQ-003.

Structure
REQ-017 Package rst_seq_pkg SHALL hold:
- the state enum (HOLD, SEQ, RUN)
- default constants for NUM_STAGES, HOLD_CYCLES and STAGE_DELAY
REQ-018 The two-flop synchronizer SHALL be a separate sub-module, rst_sync2 (ports clk, rst, rst_s), instantiated once.
REQ-019 The FSM, counter and stage register SHALL live in rst_sequencer.

Verification
Scenarios use default parameters. Edge 1 is the first rising edge after rst falls.

REQ-020 Power-on:
- rst falls -> rst_s low after edge 2
- rst_out[0] clears at edge 10
- rst_out[1] clears at edge 26
- rst_out[2] clears at edge 42
- ready=1 and busy=0 at edge 42
REQ-021 Soft request in RUN:
- stimulus: one-cycle sw_rst_req sampled at edge E
- response: rst_out=3'b111 and ready=0 at E; rst_out[0] clears at E+8; ready=1 at E+40
REQ-022 Soft request mid-SEQ:
- stimulus: sw_rst_req sampled at edge 20, when rst_out=3'b110
- response: rst_out=3'b111 at edge 20; rst_out[0] clears at edge 28
REQ-023 Held soft request:
- stimulus: sw_rst_req high for edges 50..59
- response: rst_out stays 3'b111; rst_out[0] clears at edge 67
REQ-024 Async reset in RUN:
- stimulus: rst pulse shorter than one clk period
- response: rst_out=3'b111 and ready=0 before the next edge; full sequence repeats per REQ-020
REQ-025 Ordering assertion, checked throughout all scenarios: for every i<j, rst_out[i]==1 implies rst_out[j]==1.
